// File: rtl/rotation_mode_cordic_pipeline.sv
// Rotation-mode CORDIC pipeline: applies stored micro-rotation directions to (x,y), one vector per cycle.
// Define SCALE_COMP_EN to add a gain-compensation stage (x0.6073) before the output register.
module rotation_mode_cordic_pipeline #(
  parameter int WIDTH = 12,
  parameter int ITER  = 8,
  parameter int GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic        [ITER-1:0]  dir_in,
  input  logic                    neg_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out
);
  localparam int IW = WIDTH + GUARD;
  localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    return c[WIDTH-1:0];
  endfunction

  logic adv;
  logic signed [IW-1:0] x_ext, y_ext;

  logic                 st_valid_q [ITER];
  logic                 st_valid_d [ITER];
  logic signed [IW-1:0] st_x_q     [ITER];
  logic signed [IW-1:0] st_x_d     [ITER];
  logic signed [IW-1:0] st_y_q     [ITER];
  logic signed [IW-1:0] st_y_d     [ITER];
  logic [ITER-1:0]      st_dir_q   [ITER-1];
  logic [ITER-1:0]      st_dir_d   [ITER-1];

  logic                 in_v   [ITER];
  logic signed [IW-1:0] in_x   [ITER];
  logic signed [IW-1:0] in_y   [ITER];
  logic [ITER-1:0]      in_dir [ITER];

  logic                 fin_valid;
  logic signed [IW-1:0] fin_x, fin_y;
  logic                 out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;

  // A single advance signal moves the whole pipe, so a stall freezes every stage at once.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign x_ext    = {{GUARD{x_in[WIDTH-1]}}, x_in};
  assign y_ext    = {{GUARD{y_in[WIDTH-1]}}, y_in};

  // Negation happens at internal width so that the most negative input maps exactly.
  always_comb begin
    logic signed [IW-1:0] sx, sy;
    sx = '0;
    sy = '0;
    in_v[0]   = in_valid;
    in_x[0]   = neg_in ? -x_ext : x_ext;
    in_y[0]   = neg_in ? -y_ext : y_ext;
    in_dir[0] = dir_in;
    for (int i = 1; i < ITER; i++) begin
      in_v[i]   = st_valid_q[i-1];
      in_x[i]   = st_x_q[i-1];
      in_y[i]   = st_y_q[i-1];
      in_dir[i] = st_dir_q[i-1];
    end
    for (int i = 0; i < ITER; i++) begin
      sx            = in_x[i] >>> i;
      sy            = in_y[i] >>> i;
      st_valid_d[i] = in_v[i];
      if (in_dir[i][i]) begin
        st_x_d[i] = in_x[i] + sy;
        st_y_d[i] = in_y[i] - sx;
      end else begin
        st_x_d[i] = in_x[i] - sy;
        st_y_d[i] = in_y[i] + sx;
      end
    end
    for (int i = 0; i < ITER - 1; i++) st_dir_d[i] = in_dir[i];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ITER; i++) begin
        st_valid_q[i] <= 1'b0;
        st_x_q[i]     <= '0;
        st_y_q[i]     <= '0;
      end
      for (int i = 0; i < ITER - 1; i++) st_dir_q[i] <= '0;
    end else if (adv) begin
      st_valid_q <= st_valid_d;
      st_x_q     <= st_x_d;
      st_y_q     <= st_y_d;
      st_dir_q   <= st_dir_d;
    end
  end

`ifdef SCALE_COMP_EN
  localparam int PW = IW + 10;
  localparam logic signed [PW-1:0] K_GAIN = PW'(622);

  logic                 sc_valid_q, sc_valid_d;
  logic signed [IW-1:0] sc_x_q, sc_x_d, sc_y_q, sc_y_d;

  // Q10 multiply by 0.6073; the product fits PW bits and the result fits back into IW bits.
  always_comb begin
    logic signed [PW-1:0] ext_x, ext_y, prod_x, prod_y, shf_x, shf_y;
    ext_x      = {{(PW-IW){st_x_q[ITER-1][IW-1]}}, st_x_q[ITER-1]};
    ext_y      = {{(PW-IW){st_y_q[ITER-1][IW-1]}}, st_y_q[ITER-1]};
    prod_x     = ext_x * K_GAIN;
    prod_y     = ext_y * K_GAIN;
    shf_x      = prod_x >>> 10;
    shf_y      = prod_y >>> 10;
    sc_valid_d = st_valid_q[ITER-1];
    sc_x_d     = shf_x[IW-1:0];
    sc_y_d     = shf_y[IW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sc_valid_q <= 1'b0;
      sc_x_q     <= '0;
      sc_y_q     <= '0;
    end else if (adv) begin
      sc_valid_q <= sc_valid_d;
      sc_x_q     <= sc_x_d;
      sc_y_q     <= sc_y_d;
    end
  end

  assign fin_valid = sc_valid_q;
  assign fin_x     = sc_x_q;
  assign fin_y     = sc_y_q;
`else
  assign fin_valid = st_valid_q[ITER-1];
  assign fin_x     = st_x_q[ITER-1];
  assign fin_y     = st_y_q[ITER-1];
`endif

  // Output data only changes when a valid vector lands, keeping it quiet across bubbles.
  always_comb begin
    out_valid_d = fin_valid;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    if (fin_valid) begin
      x_out_d = sat(fin_x);
      y_out_d = sat(fin_y);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
    end else if (adv) begin
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
endmodule

// File: tb/tb_rotation_mode_cordic_pipeline.sv
// Bench for rotation_mode_cordic_pipeline: directed vector table with hand-derived results,
// plus backpressure streaming and mid-stream reset sequences.
module tb_rotation_mode_cordic_pipeline;
  localparam int WIDTH = 12;
  localparam int ITER  = 8;
`ifdef SCALE_COMP_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic        [ITER-1:0]  dir_in;
  logic                    neg_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] dir;
    logic       neg;
    int         exp_x;
    int         exp_y;
  } vec_t;

  rotation_mode_cordic_pipeline #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .dir_in    (dir_in),
    .neg_in    (neg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int satModel(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference arithmetic: signed >>> on int is a floor shift.
  function automatic void cordicModel(input int x, input int y, input logic [7:0] dir,
                                      input logic neg, output int ox, output int oy);
    int a, b, na, nb;
    a = neg ? -x : x;
    b = neg ? -y : y;
    for (int i = 0; i < ITER; i++) begin
      if (!dir[i]) begin
        na = a - (b >>> i);
        nb = b + (a >>> i);
      end else begin
        na = a + (b >>> i);
        nb = b - (a >>> i);
      end
      a = na;
      b = nb;
    end
`ifdef SCALE_COMP_EN
    a = (a * 622) >>> 10;
    b = (b * 622) >>> 10;
`endif
    ox = satModel(a);
    oy = satModel(b);
  endfunction

  // Sends one vector from an idle pipe and counts clock edges until it emerges.
  task automatic applyStimulus(input int x, input int y, input logic [7:0] dir, input logic neg,
                               output int lat, output int ox, output int oy);
    x_in     = 12'(x);
    y_in     = 12'(y);
    dir_in   = dir;
    neg_in   = neg;
    in_valid = 1'b1;
    lat      = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        x_in     = 12'sd1234;
        y_in     = -12'sd777;
        dir_in   = ~dir;
        neg_in   = ~neg;
      end
    end while (!out_valid && lat < 4 * LAT);
    ox = x_out;
    oy = y_out;
  endtask

  task automatic streamTest();
    int sx [5] = '{100, -700, 1500, -2048, 37};
    int sy [5] = '{-50, 300, -1500, -2048, 911};
    logic [7:0] sd [5] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h5A};
    logic sn [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int ex [5];
    int ey [5];
    for (int k = 0; k < 5; k++) cordicModel(sx[k], sy[k], sd[k], sn[k], ex[k], ey[k]);
    out_ready = 1'b1;
    fork
      begin
        bit ok;
        int w;
        for (int k = 0; k < 5; k++) begin
          x_in     = 12'(sx[k]);
          y_in     = 12'(sy[k]);
          dir_in   = sd[k];
          neg_in   = sn[k];
          in_valid = 1'b1;
          w        = 0;
          do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            w++;
          end while (!ok && w < 100);
        end
        in_valid = 1'b0;
      end
      begin
        int  got;
        int  budget;
        bit  held;
        got    = 0;
        budget = 0;
        held   = 1'b0;
        while (got < 5 && budget < 200) begin
          @(negedge clk);
          budget++;
          if (out_valid && out_ready) begin
            checkOutput($sformatf("stream%0d_x", got), x_out, ex[got]);
            checkOutput($sformatf("stream%0d_y", got), y_out, ey[got]);
            got++;
            if (!held) begin
              held = 1'b1;
              @(posedge clk);
              #1;
              out_ready = 1'b0;
              for (int h = 0; h < 4; h++) begin
                @(negedge clk);
                checkOutput($sformatf("hold%0d_out_valid", h), out_valid, 1);
                checkOutput($sformatf("hold%0d_in_ready", h), in_ready, 0);
                checkOutput($sformatf("hold%0d_x", h), x_out, ex[1]);
                checkOutput($sformatf("hold%0d_y", h), y_out, ey[1]);
              end
              @(posedge clk);
              #1;
              out_ready = 1'b1;
            end
          end
        end
        checkOutput("stream_count", got, 5);
      end
    join
  endtask

  task automatic resetTest();
    int w;
    int stale;
    int lat, ox, oy;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x_in     = 12'(300 + 100 * k);
      y_in     = 12'(-200 * k);
      dir_in   = 8'h33;
      neg_in   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 4 * LAT) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("rst_pre_out_valid", out_valid, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_out_valid", out_valid, 0);
    checkOutput("rst_async_x_out", x_out, 0);
    checkOutput("rst_async_y_out", y_out, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("rst_stale_outputs", stale, 0);
    applyStimulus(256, 0, 8'h00, 1'b0, lat, ox, oy);
    checkOutput("rst_new_lat", lat, LAT);
`ifdef SCALE_COMP_EN
    checkOutput("rst_new_x", ox, -42);
    checkOutput("rst_new_y", oy, 251);
`else
    checkOutput("rst_new_x", ox, -68);
    checkOutput("rst_new_y", oy, 414);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs [6];
    int lat, ox, oy;
`ifdef SCALE_COMP_EN
    vecs[0] = '{256,   0,    8'h00, 1'b0, -42,   251};
    vecs[1] = '{256,   0,    8'h00, 1'b1, 43,    -254};
    vecs[2] = '{2047,  2047, 8'h00, 1'b0, -2048, 1682};
    vecs[3] = '{256,   0,    8'hFF, 1'b0, -44,   -252};
    vecs[4] = '{-2048, 0,    8'h00, 1'b1, -336,  2019};
    vecs[5] = '{0,     0,    8'hA5, 1'b1, 0,     0};
`else
    vecs[0] = '{256,   0,    8'h00, 1'b0, -68,   414};
    vecs[1] = '{256,   0,    8'h00, 1'b1, 72,    -418};
    vecs[2] = '{2047,  2047, 8'h00, 1'b0, -2048, 2047};
    vecs[3] = '{256,   0,    8'hFF, 1'b0, -72,   -414};
    vecs[4] = '{-2048, 0,    8'h00, 1'b1, -552,  2047};
    vecs[5] = '{0,     0,    8'hA5, 1'b1, 0,     0};
`endif
    rstn      = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    y_in      = '0;
    dir_in    = '0;
    neg_in    = 1'b0;
    out_ready = 1'b1;
    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_x_out", x_out, 0);
    checkOutput("reset_y_out", y_out, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].dir, vecs[i].neg, lat, ox, oy);
      checkOutput($sformatf("vec%0d_latency", i), lat, LAT);
      checkOutput($sformatf("vec%0d_x", i), ox, vecs[i].exp_x);
      checkOutput($sformatf("vec%0d_y", i), oy, vecs[i].exp_y);
      @(posedge clk);
      #1;
    end

    streamTest();
    repeat (3) @(posedge clk);
    #1;
    resetTest();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
